// File: rtl/shift_issue_pkg.sv
// Shared types and width defaults for the shift-unit issue controller.
package shift_issue_pkg;

    localparam int XLEN_D    = 32;
    localparam int SHAMT_W_D = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_issue.sv
// Issue-side controller: accepts one shift op, kicks the multi-cycle
// shift unit, waits for its result and writes it back with its rd.
module shift_issue
    import shift_issue_pkg::*;
#(
    parameter int XLEN        = XLEN_D,
    parameter int SHAMT_W     = SHAMT_W_D,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            busy,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_early,
    output logic            sh_kick,
    output logic            sh_lshift,
    output logic            sh_unsigned,
    output logic [XLEN-1:0] sh_a,
    output logic [XLEN-1:0] sh_b,
    input  logic            sh_ready,
    input  logic            sh_ready_pre,
    input  logic [XLEN-1:0] sh_q
);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [XLEN-1:0]      rs1_q, rs1_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [4:0]           rd_q, rd_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;
    logic                 killed_q, killed_d;
    logic                 accept;
    logic                 unused_rs2;

    assign unused_rs2 = ^req_rs2[XLEN-1:SHAMT_W];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        shamt_d   = shamt_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        killed_d  = killed_q;
        sh_kick   = 1'b0;
        wb_valid  = 1'b0;
        wb_early  = 1'b0;
        req_ready = ((state_q == IDLE) || (state_q == DONE)) && !flush;
        accept    = req_valid && req_ready;

        unique case (state_q)
            IDLE: ;
            KICK: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    sh_kick = 1'b1;
                    if (sh_ready) state_d = WAIT;
                end
            end
            WAIT: begin
                // The unit cannot abort, so a killed op still waits it out.
                if (flush) killed_d = 1'b1;
                wb_early = sh_ready_pre && !killed_q;
                if (sh_ready) begin
                    killed_d = 1'b0;
                    if (killed_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DONE;
                        wb_data_d = sh_q;
                    end
                end
            end
            DONE: begin
                wb_valid = !flush;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            op_d     = req_op;
            rs1_d    = req_rs1;
            shamt_d  = req_rs2[SHAMT_W-1:0];
            rd_d     = req_rd;
            killed_d = 1'b0;
            if (ZERO_BYPASS && (req_rs2[SHAMT_W-1:0] == '0)) begin
                state_d   = DONE;
                wb_data_d = req_rs1;
            end else begin
                state_d = KICK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            shamt_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            killed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            shamt_q   <= shamt_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            killed_q  <= killed_d;
        end
    end

    // Reserved op encoding 3 falls through to a left shift.
    assign sh_lshift   = !((op_q == OP_SRL) || (op_q == OP_SRA));
    assign sh_unsigned = (op_q == OP_SRL);
    assign sh_a        = rs1_q;
    assign sh_b        = {{(XLEN-SHAMT_W){1'b0}}, shamt_q};
    assign busy        = (state_q != IDLE);
    assign wb_rd       = rd_q;
    assign wb_data     = wb_data_q;

endmodule
